// File: rtl/jtkiwi_shr_pkg.sv
// Shared types and helpers for the shared work-RAM arbiter.
// Imported by the picker and the arbiter top.
package jtkiwi_shr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } shr_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Low bit of port idx inside a packed per-port bus of the given width.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/jtkiwi_shr_arb_if.sv
// Per-port request/response bundle between the CPUs and the shared-RAM arbiter.
// Packed buses carry port i at [i*W +: W].
interface jtkiwi_shr_arb_if #(
  parameter int NPORT = 3,
  parameter int AW    = 13,
  parameter int DW    = 8
);
  // Handshake: cs[i] is the request and must stay high (with we/addr/din stable)
  // until ack[i] pulses for one cycle; the access is complete on that cycle and
  // dout[i] is valid then and held until port i's next ack. cpu_wait[i] is the
  // Z80-style hold, high while a request is outstanding and not yet acked.
  logic [NPORT-1:0]    cs;
  logic [NPORT-1:0]    we;
  logic [NPORT*AW-1:0] addr;
  logic [NPORT*DW-1:0] din;
  logic [NPORT*DW-1:0] dout;
  logic [NPORT-1:0]    ack;
  logic [NPORT-1:0]    cpu_wait;
  logic                busy;

  modport master (
    output cs, we, addr, din,
    input  dout, ack, cpu_wait, busy
  );

  modport slave (
    input  cs, we, addr, din,
    output dout, ack, cpu_wait, busy
  );

endinterface

// File: rtl/jtkiwi_shr_pick.sv
// Combinational grant picker: round-robin after i_last, or fixed lowest-index.
// One instance serves both the IDLE and DONE arbitration points.
module jtkiwi_shr_pick
  import jtkiwi_shr_pkg::*;
#(
  parameter int NPORT = 3,
  parameter int PRIO  = PRIO_RR
) (
  input  logic [NPORT-1:0]         i_req,
  input  logic [$clog2(NPORT)-1:0] i_last,
  output logic                     o_valid,
  output logic [$clog2(NPORT)-1:0] o_idx
);

  localparam int IW = $clog2(NPORT);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    if (PRIO == PRIO_FIXED) begin
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = IW'(i);
      end
    end else begin
      // Scan backwards so the nearest requester after i_last is written last.
      for (int k = NPORT; k >= 1; k--) begin
        if (i_req[(int'(i_last) + k) % NPORT]) o_idx = IW'((int'(i_last) + k) % NPORT);
      end
    end
  end

endmodule

// File: rtl/jtkiwi_shr_arb.sv
// Shared work-RAM arbiter: serialises NPORT CPU requests onto one single-port RAM,
// returning a one-cycle ack and a combinational wait per port.
module jtkiwi_shr_arb
  import jtkiwi_shr_pkg::*;
#(
  parameter int NPORT = 3,
  parameter int AW    = 13,
  parameter int DW    = 8,
  parameter int PRIO  = PRIO_RR
) (
  input  logic              clk,
  input  logic              rstn,
  jtkiwi_shr_arb_if.slave   bus,
  output shr_state_t        o_state
);

  localparam int IW = $clog2(NPORT);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  shr_state_t          r_state, w_state_nx;
  logic [IW-1:0]       r_grant, r_last, w_grant_nx, w_last_nx;
  logic [NPORT-1:0]    r_served;
  logic [NPORT*DW-1:0] r_dout;

  logic [NPORT-1:0] w_req, w_pick_req, w_grant_oh, w_ack;
  logic             w_pick_valid;
  logic [IW-1:0]    w_pick_idx;
  logic [AW-1:0]    w_addr_g;
  logic [DW-1:0]    w_din_g;
  logic             w_we_g;

  assign w_grant_oh = {{(NPORT-1){1'b0}}, 1'b1} << r_grant;
  assign w_req      = bus.cs & ~r_served;
  // In DONE the port just finishing is excluded so another can start immediately.
  assign w_pick_req = (r_state == DONE) ? (w_req & ~w_grant_oh) : w_req;
  assign w_ack      = (r_state == DONE) ? w_grant_oh : '0;

  assign w_addr_g = bus.addr[slice_lo(int'(r_grant), AW) +: AW];
  assign w_din_g  = bus.din[slice_lo(int'(r_grant), DW) +: DW];
  assign w_we_g   = bus.we[r_grant];

  jtkiwi_shr_pick #(
    .NPORT (NPORT),
    .PRIO  (PRIO)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_last_nx  = r_last;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nx = ACCESS;
          w_grant_nx = w_pick_idx;
          w_last_nx  = w_pick_idx;
        end
      end
      ACCESS: w_state_nx = DONE;
      DONE: begin
        if (w_pick_valid) begin
          w_state_nx = ACCESS;
          w_grant_nx = w_pick_idx;
          w_last_nx  = w_pick_idx;
        end else begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_last   <= IW'(NPORT - 1);
      r_served <= '0;
      r_dout   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_grant  <= w_grant_nx;
      r_last   <= w_last_nx;
      // A port stays served while it keeps cs high past its ack.
      r_served <= bus.cs & (r_served | w_ack);
      if (r_state == ACCESS && !w_we_g) begin
        r_dout[slice_lo(int'(r_grant), DW) +: DW] <= r_mem[w_addr_g];
      end
    end
  end

  // RAM is never cleared; a write pending at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rstn && r_state == ACCESS && w_we_g) begin
      r_mem[w_addr_g] <= w_din_g;
    end
  end

  assign bus.dout     = r_dout;
  assign bus.ack      = w_ack;
  assign bus.cpu_wait = bus.cs & ~r_served & ~w_ack;
  assign bus.busy     = (r_state != IDLE);
  assign o_state      = r_state;

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Directed and randomized checks of the shared-RAM arbiter in round-robin and
// fixed-priority builds, against a transaction-level memory model.
module tb_jtkiwi_shr_arb;
  import jtkiwi_shr_pkg::*;

  localparam int NPORT = 3;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int PEND_MAX = 2 * NPORT - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  jtkiwi_shr_arb_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) b ();
  jtkiwi_shr_arb_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) f ();
  shr_state_t st_rr, st_fx;

  jtkiwi_shr_arb #(.NPORT(NPORT), .AW(AW), .DW(DW), .PRIO(PRIO_RR)) dut_rr (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (b.slave),
    .o_state (st_rr)
  );

  jtkiwi_shr_arb #(.NPORT(NPORT), .AW(AW), .DW(DW), .PRIO(PRIO_FIXED)) dut_fx (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (f.slave),
    .o_state (st_fx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input bit fx, input int p, input logic c, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (fx) begin
      f.cs[p] = c; f.we[p] = w; f.addr[p*AW +: AW] = a; f.din[p*DW +: DW] = d;
    end else begin
      b.cs[p] = c; b.we[p] = w; b.addr[p*AW +: AW] = a; b.din[p*DW +: DW] = d;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    b.cs = '0;
    f.cs = '0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  // Test-local state
  int ph[NPORT];
  int ack_p[$];
  int ack_c[$];
  logic [NPORT-1:0] a_s, w_s, c_s;
  // Random-phase transaction model
  logic [DW-1:0] mm [int];
  bit            act[NPORT];
  bit            pwe[NPORT];
  logic [AW-1:0] paddr[NPORT];
  logic [DW-1:0] pdin[NPORT];
  int            idle_n[NPORT];
  int            pend[NPORT];
  logic [DW-1:0] exp_dout[NPORT];
  bit            exp_known[NPORT];
  int            pick;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    b.cs = '0; b.we = '0; b.addr = '0; b.din = '0;
    f.cs = '0; f.we = '0; f.addr = '0; f.din = '0;

    // 1: reset with every cs asserted; port 0 wins first after release
    rstn = 1'b0;
    b.cs = '1;
    cyc();
    cyc();
    chk("rst_ack", b.ack, 0);
    chk("rst_dout", b.dout, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_state", st_rr, IDLE);
    rstn = 1'b1;
    cyc();
    chk("rst_rel_ack", b.ack, 0);
    chk("rst_rel_busy", b.busy, 1);
    cyc();
    chk("rst_first_ack", b.ack, 3'b001);
    b.cs = '0;
    cyc();
    cyc();
    chk("rst_back_idle", b.busy, 0);

    // 2: single port write then read, served hold suppresses duplicate access
    drive(0, 1, 1, 1, 13'h0123, 8'hA5);
    cyc();
    chk("t2_wr_wait", b.cpu_wait[1], 1);
    chk("t2_wr_noack", b.ack, 0);
    cyc();
    chk("t2_wr_ack", b.ack, 3'b010);
    chk("t2_wr_wait_ack", b.cpu_wait[1], 0);
    chk("t2_wr_dout_kept", b.dout[1*DW +: DW], 0);
    b.cs[1] = 1'b0;
    cyc();
    drive(0, 1, 1, 0, 13'h0123, 8'h00);
    cyc();
    chk("t2_rd_wait", b.cpu_wait[1], 1);
    cyc();
    chk("t2_rd_ack", b.ack, 3'b010);
    chk("t2_rd_dout", b.dout[1*DW +: DW], 8'hA5);
    cyc();
    chk("t2_hold_noack", b.ack, 0);
    chk("t2_hold_nowait", b.cpu_wait[1], 0);
    chk("t2_hold_idle", st_rr, IDLE);
    cyc();
    chk("t2_hold_noack2", b.ack, 0);
    b.cs[1] = 1'b0;
    cyc();

    // 3: round-robin fairness with all ports re-requesting one cycle after ack
    do_reset();
    for (int p = 0; p < NPORT; p++) begin
      ph[p] = 0;
      drive(0, p, 1, 0, AW'(p), 8'h00);
    end
    for (int n = 1; n <= 12; n++) begin
      cyc();
      a_s = b.ack;
      chk("t3_onehot", 32'($onehot0(a_s)), 1);
      for (int p = 0; p < NPORT; p++) begin
        if (ph[p] == 2) begin b.cs[p] = 1'b0; ph[p] = 1; end
        else if (ph[p] == 1) begin b.cs[p] = 1'b1; ph[p] = 0; end
      end
      for (int p = 0; p < NPORT; p++) begin
        if (a_s[p]) begin
          ack_p.push_back(p);
          ack_c.push_back(n);
          ph[p] = 2;
        end
      end
    end
    chk("t3_ack_count", ack_p.size(), 6);
    for (int k = 0; k < 6 && k < ack_p.size(); k++) begin
      chk("t3_order", ack_p[k], k % NPORT);
      chk("t3_spacing", ack_c[k], 2 * (k + 1));
    end
    b.cs = '0;
    for (int n = 0; n < 10 && b.busy; n++) cyc();
    chk("t3_drain", b.busy, 0);

    // 4: after port 1, ports 0 and 2 together: RR goes to 2, fixed to 0
    do_reset();
    drive(0, 1, 1, 0, 13'h0123, 8'h00);
    drive(1, 1, 1, 0, 13'h0123, 8'h00);
    cyc();
    cyc();
    chk("t4_rr_p1", b.ack, 3'b010);
    chk("t4_fx_p1", f.ack, 3'b010);
    drive(0, 1, 0, 0, 13'h0123, 8'h00);
    drive(1, 1, 0, 0, 13'h0123, 8'h00);
    drive(0, 0, 1, 0, 13'h0123, 8'h00);
    drive(0, 2, 1, 0, 13'h0000, 8'h00);
    drive(1, 0, 1, 0, 13'h0123, 8'h00);
    drive(1, 2, 1, 0, 13'h0000, 8'h00);
    cyc();
    cyc();
    chk("t4_rr_first", b.ack, 3'b100);
    chk("t4_fx_first", f.ack, 3'b001);
    b.cs[2] = 1'b0;
    f.cs[0] = 1'b0;
    cyc();
    cyc();
    chk("t4_rr_second", b.ack, 3'b001);
    chk("t4_fx_second", f.ack, 3'b100);
    chk("t4_rr_dout0", b.dout[0*DW +: DW], 8'hA5);
    b.cs = '0;
    f.cs = '0;
    cyc();
    cyc();

    // 5: same-cycle write (port 0) and read (port 2) of 0x1FFF
    do_reset();
    drive(0, 0, 1, 1, 13'h1FFF, 8'h3C);
    drive(0, 2, 1, 0, 13'h1FFF, 8'h00);
    cyc();
    cyc();
    chk("t5_wr_first", b.ack, 3'b001);
    b.cs[0] = 1'b0;
    cyc();
    cyc();
    chk("t5_rd_second", b.ack, 3'b100);
    chk("t5_rd_data", b.dout[2*DW +: DW], 8'h3C);
    b.cs[2] = 1'b0;
    cyc();

    // 6: reset during ACCESS of a write drops the write and the ack
    drive(0, 1, 1, 1, 13'h0010, 8'h11);
    cyc();
    cyc();
    chk("t6_pre_ack", b.ack, 3'b010);
    b.cs[1] = 1'b0;
    cyc();
    drive(0, 1, 1, 1, 13'h0010, 8'h77);
    cyc();
    chk("t6_in_access", st_rr, ACCESS);
    rstn = 1'b0;
    b.cs[1] = 1'b0;
    cyc();
    chk("t6_rst_noack", b.ack, 0);
    chk("t6_rst_idle", st_rr, IDLE);
    rstn = 1'b1;
    cyc();
    chk("t6_rel_noack", b.ack, 0);
    drive(0, 1, 1, 0, 13'h0010, 8'h00);
    cyc();
    cyc();
    chk("t6_rd_ack", b.ack, 3'b010);
    chk("t6_rd_data", b.dout[1*DW +: DW], 8'h11);
    b.cs[1] = 1'b0;
    cyc();

    // 7: randomized traffic against a transaction-level memory model
    do_reset();
    for (int p = 0; p < NPORT; p++) begin
      act[p] = 0; idle_n[p] = 0; pend[p] = 0;
      exp_dout[p] = '0; exp_known[p] = 1;
    end
    for (int n = 0; n < 600; n++) begin
      cyc();
      a_s = b.ack;
      w_s = b.cpu_wait;
      c_s = b.cs;
      chk("rnd_onehot", 32'($onehot0(a_s)), 1);
      chk("rnd_wait", w_s, c_s & ~a_s);
      for (int p = 0; p < NPORT; p++) begin
        if (a_s[p]) begin
          chk("rnd_ack_active", act[p], 1);
          chk("rnd_latency_ok", pend[p] <= PEND_MAX, 1);
          if (pwe[p]) begin
            mm[int'(paddr[p])] = pdin[p];
            if (exp_known[p]) chk("rnd_wr_dout", b.dout[p*DW +: DW], exp_dout[p]);
          end else if (mm.exists(int'(paddr[p]))) begin
            chk("rnd_rd_data", b.dout[p*DW +: DW], mm[int'(paddr[p])]);
            exp_dout[p] = mm[int'(paddr[p])];
            exp_known[p] = 1;
          end else begin
            exp_known[p] = 0;
          end
          act[p] = 0;
          b.cs[p] = 1'b0;
          idle_n[p] = $urandom_range(0, 3);
        end else if (act[p]) begin
          pend[p]++;
          chk("rnd_pending_bound", pend[p] <= PEND_MAX, 1);
        end else if (idle_n[p] > 0) begin
          idle_n[p]--;
        end else begin
          pick = $urandom_range(0, 15);
          paddr[p] = (pick < 8) ? AW'(pick) : AW'(13'h1FF0 + pick);
          pwe[p]   = 1'($urandom_range(0, 1));
          pdin[p]  = DW'($urandom);
          pend[p]  = 0;
          act[p]   = 1;
          drive(0, p, 1, pwe[p], paddr[p], pdin[p]);
        end
      end
    end
    b.cs = '0;
    cyc();
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
